// File: rtl/ctrl_word_loader_pkg.sv
// Shared types and constants for the serial control-word loader and the
// code-gated select stage it feeds.
package ctrl_word_loader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_CODE = 2'd1,
        LOAD_DATA = 2'd2,
        HOLD      = 2'd3
    } state_t;

    localparam int DEF_CTRL_W = 6;
    localparam int DEF_DATA_W = 4;

    localparam logic [DEF_CTRL_W-1:0] CODE_ALL_ONES = {DEF_CTRL_W{1'b1}};

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ctrl_word_loader_if.sv
// Serial frame input and registered select-stage outputs of the loader.
interface ctrl_word_loader_if
    import ctrl_word_loader_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              start;
    logic              ser_in;
    logic              ser_valid;
    logic [CTRL_W-1:0] code_out;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              busy;

    modport master (
        output start, ser_in, ser_valid,
        input  code_out, data_out, out_valid, busy
    );

    modport slave (
        input  start, ser_in, ser_valid,
        output code_out, data_out, out_valid, busy
    );
endinterface

// File: rtl/ctrl_word_loader_shift_collector.sv
// MSB-first staging shift register: the first bit shifted in ends up in the
// leftmost (most significant) position once W bits have been accepted.
module shift_collector #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q << 1) | W'(din);
        end
    end
endmodule

// File: rtl/ctrl_word_loader.sv
// Assembles a select code and data word from a framed serial stream and
// presents them, fully registered, for a bounded hold window.
module ctrl_word_loader
    import ctrl_word_loader_pkg::*;
#(
    parameter int CTRL_W      = DEF_CTRL_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    ctrl_word_loader_if.slave   bus
);
    localparam int BIT_CNT_W = $clog2(max_int(CTRL_W, DATA_W) + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_CODE = BIT_CNT_W'(CTRL_W - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_W - 1);
    localparam logic [7:0]           HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t               state, state_n;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [7:0]           hold_cnt, hold_cnt_n;
    logic [CTRL_W-1:0]    code_q, code_n;
    logic [DATA_W-1:0]    data_q, data_n;
    logic                 valid_q, valid_n;
    logic                 busy_q, busy_n;

    logic                 clr_stage, shift_code, shift_data;
    logic [CTRL_W-1:0]    code_stage;
    logic [DATA_W-1:0]    data_stage;
    logic [DATA_W-1:0]    data_stage_next;

    shift_collector #(.W(CTRL_W)) u_code_stage (
        .clk (clk),
        .rst (rst),
        .clr (clr_stage),
        .en  (shift_code),
        .din (bus.ser_in),
        .q   (code_stage)
    );

    shift_collector #(.W(DATA_W)) u_data_stage (
        .clk (clk),
        .rst (rst),
        .clr (clr_stage),
        .en  (shift_data),
        .din (bus.ser_in),
        .q   (data_stage)
    );

    // The final data bit is still in flight when outputs load, so fold it in here.
    assign data_stage_next = (data_stage << 1) | DATA_W'(bus.ser_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            hold_cnt <= '0;
            code_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            hold_cnt <= hold_cnt_n;
            code_q   <= code_n;
            data_q   <= data_n;
            valid_q  <= valid_n;
            busy_q   <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        hold_cnt_n = hold_cnt;
        code_n     = code_q;
        data_n     = data_q;
        valid_n    = valid_q;
        clr_stage  = 1'b0;
        shift_code = 1'b0;
        shift_data = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n   = LOAD_CODE;
                    bit_cnt_n = '0;
                    clr_stage = 1'b1;
                end
            end
            LOAD_CODE: begin
                if (bus.start) begin
                    bit_cnt_n = '0;
                    clr_stage = 1'b1;
                end else if (bus.ser_valid) begin
                    shift_code = 1'b1;
                    if (bit_cnt == LAST_CODE) begin
                        state_n   = LOAD_DATA;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            LOAD_DATA: begin
                if (bus.start) begin
                    state_n   = LOAD_CODE;
                    bit_cnt_n = '0;
                    clr_stage = 1'b1;
                end else if (bus.ser_valid) begin
                    shift_data = 1'b1;
                    if (bit_cnt == LAST_DATA) begin
                        state_n    = HOLD;
                        bit_cnt_n  = '0;
                        code_n     = code_stage;
                        data_n     = data_stage_next;
                        valid_n    = 1'b1;
                        hold_cnt_n = HOLD_LOAD;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // data_out deliberately keeps its value when the window closes.
                if (bus.start) begin
                    state_n   = LOAD_CODE;
                    bit_cnt_n = '0;
                    clr_stage = 1'b1;
                    code_n    = '0;
                    valid_n   = 1'b0;
                end else if (hold_cnt == 8'd0) begin
                    state_n = IDLE;
                    code_n  = '0;
                    valid_n = 1'b0;
                end else begin
                    hold_cnt_n = hold_cnt - 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == LOAD_CODE) || (state_n == LOAD_DATA);
    end

    assign bus.code_out  = code_q;
    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;

endmodule
